// File: rtl/cpu_mem_arbiter.sv
// Arbitrates CPU instruction-fetch and data requests onto one sram-like port and
// routes in-order responses back to their issuers through an owner FIFO.
module cpu_mem_arbiter #(
    parameter int MAX_OUT      = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        ram_req,
    output logic        ram_wr,
    output logic [1:0]  ram_size,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_addr_ok,
    input  logic        ram_data_ok,
    input  logic [31:0] ram_rdata,
    output logic        err
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;

    owner_e             owner_q [MAX_OUT];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               lock_q, lock_d;
    owner_e             lock_owner_q, lock_owner_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic               err_q, err_d;

    owner_e             grant;
    logic               full;
    logic               push;
    logic               pop;
    owner_e             head;

    assign full = (count_q == CNT_W'(MAX_OUT));
    assign head = owner_q[rd_ptr_q];

    // While locked the registered owner holds the port; otherwise data has priority
    // unless inst has waited through STARVE_LIMIT data grants.
    always_comb begin
        grant = OWN_INST;
        if (lock_q) begin
            grant = lock_owner_q;
        end else if (data_req && !(inst_req && starve_q == STV_W'(STARVE_LIMIT))) begin
            grant = OWN_DATA;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        ram_req      = !reset && (inst_req || data_req) && !full;
        ram_wr       = (grant == OWN_DATA) ? data_wr    : inst_wr;
        ram_size     = (grant == OWN_DATA) ? data_size  : inst_size;
        ram_addr     = (grant == OWN_DATA) ? data_addr  : inst_addr;
        ram_wdata    = (grant == OWN_DATA) ? data_wdata : inst_wdata;
        push         = ram_req && ram_addr_ok;
        pop          = !reset && ram_data_ok && (count_q != '0);
        inst_addr_ok = push && (grant == OWN_INST);
        data_addr_ok = push && (grant == OWN_DATA);
        inst_data_ok = pop && (head == OWN_INST);
        data_data_ok = pop && (head == OWN_DATA);
        inst_rdata   = ram_rdata;
        data_rdata   = ram_rdata;
        err          = err_q;
    end

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q;
        if (push && !pop) count_d = count_q + CNT_W'(1);
        if (!push && pop) count_d = count_q - CNT_W'(1);

        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        if (ram_req) begin
            lock_d       = !ram_addr_ok;
            lock_owner_d = grant;
        end

        starve_d = starve_q;
        if (!inst_req || (push && grant == OWN_INST)) begin
            starve_d = '0;
        end else if (push && starve_q != STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STV_W'(1);
        end

        err_d = err_q || (ram_data_ok && count_q == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_INST;
            starve_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            starve_q     <= starve_d;
            err_q        <= err_d;
        end
    end

    // NOTE: the owner storage is not reset; count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) owner_q[wr_ptr_q] <= grant;
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomized and directed bench for cpu_mem_arbiter against a queue-based model.
module tb_cpu_mem_arbiter;

    localparam int MAX_OUT      = 4;
    localparam int STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd2;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd2;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        ram_addr_ok = 1'b0, ram_data_ok = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        ram_req, ram_wr;
    logic [1:0]  ram_size;
    logic [31:0] ram_addr, ram_wdata;
    logic        err;

    cpu_mem_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .ram_req(ram_req), .ram_wr(ram_wr), .ram_size(ram_size),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_addr_ok(ram_addr_ok), .ram_data_ok(ram_data_ok), .ram_rdata(ram_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: owner queue in acceptance order, starve count, held grant.
    bit q[$];
    int starve   = 0;
    bit locked   = 0;
    bit lock_g   = 0;
    bit m_err    = 0;
    bit e_req, e_g, e_acc, e_pop, head;
    bit i_pend = 0, d_pend = 0;

    task automatic settle_and_check();
        #4;
        e_req = !reset && (inst_req || data_req) && (q.size() != MAX_OUT);
        if (locked) e_g = lock_g;
        else        e_g = data_req && !(inst_req && starve == STARVE_LIMIT);
        e_acc = e_req && ram_addr_ok;
        e_pop = !reset && ram_data_ok && (q.size() > 0);
        head  = (q.size() > 0) ? q[0] : 1'b0;
        check("ram_req", 64'(ram_req), 64'(e_req));
        if (e_req) begin
            check("ram_addr", 64'(ram_addr), 64'(e_g ? data_addr : inst_addr));
            check("ram_ctl", {29'd0, ram_wr, ram_size, ram_wdata},
                  e_g ? {29'd0, data_wr, data_size, data_wdata}
                      : {29'd0, inst_wr, inst_size, inst_wdata});
        end
        check("inst_addr_ok", 64'(inst_addr_ok), 64'(e_acc && !e_g));
        check("data_addr_ok", 64'(data_addr_ok), 64'(e_acc && e_g));
        check("inst_data_ok", 64'(inst_data_ok), 64'(e_pop && !head));
        check("data_data_ok", 64'(data_data_ok), 64'(e_pop && head));
        if (e_pop) check("rdata", 64'(head ? data_rdata : inst_rdata), 64'(ram_rdata));
        check("err", 64'(err), 64'(m_err));
    endtask

    task automatic advance();
        if (reset) begin
            q.delete();
            starve = 0;
            locked = 0;
            m_err  = 0;
        end else begin
            if (ram_data_ok && q.size() == 0) m_err = 1;
            if (e_pop) void'(q.pop_front());
            if (e_acc) q.push_back(e_g);
            if (!inst_req)  starve = 0;
            else if (e_acc) starve = e_g ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
            if (e_req) begin
                locked = !ram_addr_ok;
                lock_g = e_g;
            end
        end
        i_pend = inst_req && !(e_acc && !e_g);
        d_pend = data_req && !(e_acc && e_g);
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle_and_check();
        advance();
    endtask

    task automatic idle_drain();
        inst_req = 0; data_req = 0; ram_addr_ok = 0;
        for (int n = 0; n < 20 && q.size() > 0; n++) begin
            ram_data_ok = 1; ram_rdata = $urandom;
            step();
        end
        ram_data_ok = 0;
        check("drained", 64'(q.size()), 64'd0);
        step();
    endtask

    initial begin
        @(posedge clk); #1;
        step(); step();
        reset = 0;
        check("rst_err", 64'(err), 64'd0);
        check("rst_ram_req", 64'(ram_req), 64'd0);

        // single inst word read
        inst_req = 1; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'hBFC0_0000; ram_addr_ok = 1;
        settle_and_check();
        check("t1_iaok", 64'(inst_addr_ok), 64'd1);
        advance();
        inst_req = 0; ram_addr_ok = 0; ram_data_ok = 1; ram_rdata = 32'h3C1D_0001;
        settle_and_check();
        check("t1_idok", 64'(inst_data_ok), 64'd1);
        check("t1_rdata", 64'(inst_rdata), 64'h3C1D_0001);
        check("t1_ddok", 64'(data_data_ok), 64'd0);
        advance();
        ram_data_ok = 0;
        check("t1_count", 64'(dut.count_q), 64'd0);
        step();

        // both held: D,D,D,I pattern
        inst_req = 1; data_req = 1; inst_addr = 32'h100; data_addr = 32'h200; ram_addr_ok = 1;
        for (int k = 0; k < 8; k++) begin
            ram_data_ok = (q.size() > 0); ram_rdata = 32'(k);
            settle_and_check();
            check("t2_inst_grant", 64'(inst_addr_ok), 64'((k % 4) == 3));
            check("t2_data_grant", 64'(data_addr_ok), 64'((k % 4) != 3));
            advance();
        end
        idle_drain();

        // lock holds inst while data arrives
        inst_req = 1; inst_addr = 32'h0000_1000; ram_addr_ok = 0; data_addr = 32'h0000_2000;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) data_req = 1;
            settle_and_check();
            check("t3_locked_addr", 64'(ram_addr), 64'h1000);
            advance();
        end
        ram_addr_ok = 1;
        settle_and_check();
        check("t3_inst_wins", 64'(inst_addr_ok), 64'd1);
        check("t3_data_waits", 64'(data_addr_ok), 64'd0);
        advance();
        inst_req = 0;
        settle_and_check();
        check("t3_data_next", 64'(data_addr_ok), 64'd1);
        advance();
        idle_drain();

        // fill FIFO
        data_req = 1; ram_addr_ok = 1; ram_data_ok = 0;
        for (int k = 0; k < 4; k++) begin
            data_addr = 32'(k * 4);
            step();
        end
        ram_data_ok = 1; ram_rdata = 32'hAAAA_5555;
        settle_and_check();
        check("t4_full_req", 64'(ram_req), 64'd0);
        check("t4_ddok", 64'(data_data_ok), 64'd1);
        advance();
        ram_data_ok = 0;
        settle_and_check();
        check("t4_reassert", 64'(ram_req), 64'd1);
        advance();
        idle_drain();

        // I,D,I ordering
        ram_addr_ok = 1;
        inst_req = 1; data_req = 0; step();
        inst_req = 0; data_req = 1; step();
        inst_req = 1; data_req = 0; step();
        inst_req = 0; ram_addr_ok = 0; ram_data_ok = 1;
        ram_rdata = 32'h11; settle_and_check();
        check("t5_r1", {inst_data_ok, data_data_ok, inst_rdata}, {1'b1, 1'b0, 32'h11});
        advance();
        ram_rdata = 32'h22; settle_and_check();
        check("t5_r2", {inst_data_ok, data_data_ok, data_rdata}, {1'b0, 1'b1, 32'h22});
        advance();
        ram_rdata = 32'h33; settle_and_check();
        check("t5_r3", {inst_data_ok, data_data_ok, inst_rdata}, {1'b1, 1'b0, 32'h33});
        advance();
        ram_data_ok = 0;
        step();

        // stray response sets sticky err
        ram_data_ok = 1;
        settle_and_check();
        check("t6_no_dok", {inst_data_ok, data_data_ok}, 64'd0);
        advance();
        ram_data_ok = 0;
        settle_and_check();
        check("t6_err", 64'(err), 64'd1);
        advance();
        settle_and_check();
        check("t6_err_sticky", 64'(err), 64'd1);
        advance();
        reset = 1; step(); reset = 0;
        settle_and_check();
        check("t6_err_clr", 64'(err), 64'd0);
        check("t6_req_clr", 64'(ram_req), 64'd0);
        advance();

        // randomized traffic with protocol-respecting requesters
        for (int n = 0; n < 3000; n++) begin
            if (!i_pend) begin
                inst_req = ($urandom_range(0, 9) < 6); inst_wr = $urandom_range(0, 1);
                inst_size = 2'($urandom_range(0, 2)); inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!d_pend) begin
                data_req = ($urandom_range(0, 9) < 6); data_wr = $urandom_range(0, 1);
                data_size = 2'($urandom_range(0, 2)); data_addr = $urandom; data_wdata = $urandom;
            end
            ram_addr_ok = ($urandom_range(0, 9) < 7);
            ram_data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            ram_rdata   = $urandom;
            step();
        end
        idle_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one sram-like memory port between the CPU instruction-fetch and data-access requesters. Both requesters use the split req/addr_ok/data_ok handshake.
- Sits between the CPU top and the memory/bridge.
- Grants one address phase per cycle and tracks outstanding transactions in an in-order owner FIFO, so each response is routed to the requester that issued it.
- Data side has fixed priority; an anti-starvation counter guarantees instruction fetch forward progress.

Parameters:
- MAX_OUT, 4, maximum outstanding accepted-but-unanswered transactions (power of 2, ≥2); depth of the owner FIFO.
- STARVE_LIMIT, 3, consecutive data grants allowed while inst_req is pending before inst is forced to win.

Ports:
- clk in 1: clock.
- reset in 1: synchronous active-high reset.
- inst_req / data_req in 1: request valid.
- inst_wr / data_wr in 1: 1 = write.
- inst_size / data_size in 2: 0 = byte, 1 = half, 2 = word.
- inst_addr / data_addr in 32: byte address.
- inst_wdata / data_wdata in 32: write data.
- inst_addr_ok / data_addr_ok out 1: address phase accepted this cycle.
- inst_data_ok / data_data_ok out 1: response for the oldest accepted transaction of that requester.
- inst_rdata / data_rdata out 32: read data, valid with the matching data_ok.
- ram_req out 1, ram_wr out 1, ram_size out 2, ram_addr out 32, ram_wdata out 32: downstream request.
- ram_addr_ok in 1, ram_data_ok in 1, ram_rdata in 32: downstream handshake and read data.
- err out 1: sticky protocol error.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - ram_req = 0; all addr_ok, data_ok and err = 0.
  - FIFO empty (count 0); grant lock cleared; starve counter = 0.
  - inst_rdata and data_rdata are combinational copies of ram_rdata and are not reset.
- Address phase:
  - ram_req = (inst_req | data_req) & (count != MAX_OUT).
  - ram_wr, ram_size, ram_addr and ram_wdata are muxed from the granted requester.
  - Handshake completes when ram_req & ram_addr_ok.
  - addr_ok is asserted only to the granted requester, combinationally in the same cycle.
- Grant selection, evaluated when not locked:
  - Default: data wins if data_req.
  - Inst wins if inst_req and (no data_req, or starve counter == STARVE_LIMIT).
- Grant lock:
  - If ram_req = 1 and ram_addr_ok = 0, the chosen grant is registered as locked.
  - While locked, the grant cannot change even if the other side raises req. Requesters must hold their signals stable until addr_ok.
  - Lock clears on the accepting cycle.
- Starve counter:
  - Increments on each accepted data grant while inst_req = 1, saturating at STARVE_LIMIT.
  - Clears on an accepted inst grant or any cycle with inst_req = 0.
- Owner FIFO:
  - On acceptance, push the owner bit (0 = inst, 1 = data).
  - On ram_data_ok with a non-empty FIFO, pop the head and pulse the head owner's data_ok for one cycle, in the same cycle as ram_data_ok (zero added latency).
  - Push and pop in the same cycle leave count unchanged. This is legal even when count == MAX_OUT only if the pop frees the slot; ram_req still uses the registered count, so it stays 0 while full.
  - Pointers wrap modulo MAX_OUT.
- Full: while count == MAX_OUT, no new address phase. A locked grant cannot coexist with full, because count only rises on acceptance, which clears the lock.
- Protocol error: ram_data_ok while the FIFO is empty sets err (sticky until reset). Both data_ok outputs stay 0 and the FIFO is unchanged.
- Reset mid-operation: all in-flight tracking is discarded. The memory side shares reset, so stale responses do not arrive; any that do set err.
- Ordering: responses are strictly in acceptance order across both requesters. The downstream side must be in-order.

Test Plan:
- Single inst word read at 0xBFC00000, ram_addr_ok = 1, ram_data_ok one cycle later with rdata 0x3C1D0001 → inst_addr_ok pulses in the request cycle; inst_data_ok = 1 with inst_rdata = 0x3C1D0001; data_data_ok stays 0; count returns to 0.
- inst_req and data_req held high together, ram_addr_ok = 1 every cycle, responses returned promptly → grant sequence D,D,D,I,D,D,D,I…; the inst grant occurs exactly on the 4th cycle.
- ram_addr_ok = 0 for 3 cycles with inst granted first, data_req rising in cycle 2 → ram_addr stays the inst address; inst wins on the 4th cycle; data is granted next.
- Issue 4 data reads with ram_data_ok held 0 → count = 4 and ram_req = 0. Then one ram_data_ok → data_data_ok = 1 and ram_req reasserts the next cycle.
- Interleave I,D,I accepted, then 3 ram_data_ok pulses with rdata 0x11, 0x22, 0x33 → inst gets 0x11, data gets 0x22, inst gets 0x33.
- ram_data_ok with an empty FIFO → err = 1 and stays set; both data_ok = 0. Then reset → err = 0 and ram_req = 0.
